// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-mode interrupt controller.
// Registers the external/timer/software requests and picks one by fixed priority
// MEI > MSI > MTI. It then runs the trap handshake IDLE -> REQ -> ACTIVE -> IDLE.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchronizer ahead of each pending bit.
module irq_ctrl #(
  parameter logic [11:0] MIP = 12'h344
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        meip_in,
  input  logic        mtip_in,
  input  logic        msip_in,
  input  logic        meie_in,
  input  logic        mtie_in,
  input  logic        msie_in,
  input  logic        mstatus_mie_in,
  input  logic        trap_ack_in,
  input  logic        mret_in,
  input  logic [11:0] csr_addr_in,
  output logic        trap_req_out,
  output logic [31:0] mcause_out,
  output logic        irq_active_out,
  output logic [31:0] mip_reg_out,
  output logic        mip_hit_out
);

  localparam int unsigned NSRC = 3;
  localparam int unsigned CW   = 4;
  localparam logic [CW-1:0] CODE_MEI = 4'd11;
  localparam logic [CW-1:0] CODE_MSI = 4'd3;
  localparam logic [CW-1:0] CODE_MTI = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  // Request vector ordering: {meip, mtip, msip}
  logic [NSRC-1:0] raw_irq;
  logic [NSRC-1:0] pend_src;
  logic [NSRC-1:0] pend_q;

  assign raw_irq = {meip_in, mtip_in, msip_in};

`ifdef IRQ_SYNC_EN
  logic [NSRC-1:0] sync1_q;
  logic [NSRC-1:0] sync2_q;

  // Two-stage synchronizer for requests arriving from other clock domains
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_irq;
      sync2_q <= sync1_q;
    end
  end

  assign pend_src = sync2_q;
`else
  assign pend_src = raw_irq;
`endif

  // Pending bits: a registered copy of the request levels, refreshed every cycle
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_src;
    end
  end

  logic meip, mtip, msip;
  assign meip = pend_q[2];
  assign mtip = pend_q[1];
  assign msip = pend_q[0];

  logic mei_en, msi_en, mti_en, eligible;
  assign mei_en   = meip & meie_in;
  assign msi_en   = msip & msie_in;
  assign mti_en   = mtip & mtie_in;
  assign eligible = mstatus_mie_in & (mei_en | msi_en | mti_en);

  logic [CW-1:0] sel_code;
  // Fixed-priority cause selection
  always_comb begin
    sel_code = CODE_MTI;
    if (mei_en)      sel_code = CODE_MEI;
    else if (msi_en) sel_code = CODE_MSI;
  end

  state_e        state_q, state_d;
  logic          trap_req_q, trap_req_d;
  logic          irq_active_q, irq_active_d;
  logic [31:0]   mcause_q, mcause_d;
  logic          cause_live;

  // Is the cause latched in mcause still pending and enabled?
  always_comb begin
    cause_live = 1'b0;
    case (mcause_q[CW-1:0])
      CODE_MEI: cause_live = mei_en;
      CODE_MSI: cause_live = msi_en;
      CODE_MTI: cause_live = mti_en;
      default:  cause_live = 1'b0;
    endcase
  end

  // Next-state and output decode; acknowledge takes precedence over withdrawal
  always_comb begin
    state_d      = state_q;
    trap_req_d   = trap_req_q;
    irq_active_d = irq_active_q;
    mcause_d     = mcause_q;
    case (state_q)
      ST_IDLE: begin
        if (eligible) begin
          state_d    = ST_REQ;
          trap_req_d = 1'b1;
          mcause_d   = {1'b1, 27'b0, sel_code};
        end
      end
      ST_REQ: begin
        if (trap_ack_in) begin
          state_d      = ST_ACTIVE;
          trap_req_d   = 1'b0;
          irq_active_d = 1'b1;
        end else if (!mstatus_mie_in || !cause_live) begin
          state_d    = ST_IDLE;
          trap_req_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (mret_in) begin
          state_d      = ST_IDLE;
          irq_active_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        trap_req_d   = 1'b0;
        irq_active_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      trap_req_q   <= 1'b0;
      irq_active_q <= 1'b0;
      mcause_q     <= '0;
    end else begin
      state_q      <= state_d;
      trap_req_q   <= trap_req_d;
      irq_active_q <= irq_active_d;
      mcause_q     <= mcause_d;
    end
  end

  assign trap_req_out   = trap_req_q;
  assign irq_active_out = irq_active_q;
  assign mcause_out     = mcause_q;
  assign mip_reg_out    = {20'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0};
  assign mip_hit_out    = (csr_addr_in == MIP);

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: a scoreboard of expected per-cycle outputs, popped after each edge.
// Honours IRQ_SYNC_EN by stretching the waits for pending bits to settle.
module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
  localparam int unsigned SD = 2;
`else
  localparam int unsigned SD = 0;
`endif

  localparam logic [31:0] C_MEI = 32'h8000000B;
  localparam logic [31:0] C_MSI = 32'h80000003;
  localparam logic [31:0] C_MTI = 32'h80000007;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        meip, mtip, msip, meie, mtie, msie, mie, ack, mret;
  logic [11:0] csr_addr;
  logic        trap_req, irq_active, mip_hit;
  logic [31:0] mcause, mip_reg;

  typedef struct packed {
    logic        tr;
    logic [31:0] mc;
    logic        ia;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   step     = 0;

  irq_ctrl #(.MIP(12'h344)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .meip_in        (meip),
    .mtip_in        (mtip),
    .msip_in        (msip),
    .meie_in        (meie),
    .mtie_in        (mtie),
    .msie_in        (msie),
    .mstatus_mie_in (mie),
    .trap_ack_in    (ack),
    .mret_in        (mret),
    .csr_addr_in    (csr_addr),
    .trap_req_out   (trap_req),
    .mcause_out     (mcause),
    .irq_active_out (irq_active),
    .mip_reg_out    (mip_reg),
    .mip_hit_out    (mip_hit)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare DUT outputs after each rising edge against the oldest scoreboard entry
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      step++;
      check_val($sformatf("trap_req@%0d", step), 32'(trap_req), 32'(e.tr));
      check_val($sformatf("mcause@%0d", step), mcause, e.mc);
      check_val($sformatf("irq_active@%0d", step), 32'(irq_active), 32'(e.ia));
    end
  end

  // One clock: queue the outputs expected after the coming edge, then return at the negedge
  task automatic cyc(input logic tr, input logic [31:0] mc, input logic ia);
    exp_t e;
    e.tr = tr;
    e.mc = mc;
    e.ia = ia;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Extra cycles for synchronizer latency (none in the default build)
  task automatic ws(input logic tr, input logic [31:0] mc, input logic ia);
    for (int i = 0; i < int'(SD); i++) cyc(tr, mc, ia);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    {meip, mtip, msip, meie, mtie, msie, mie, ack, mret} = '0;
    csr_addr = 12'h000;
    #3;
    check_val("rst_trap_req", 32'(trap_req), 32'd0);
    check_val("rst_mcause", mcause, 32'd0);
    check_val("rst_irq_active", 32'(irq_active), 32'd0);
    check_val("rst_mip_reg", mip_reg, 32'd0);
    check_val("mip_hit_miss", 32'(mip_hit), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single external interrupt: request two edges after the input rises
    mie = 1'b1; meie = 1'b1; meip = 1'b1;
    cyc(0, 32'd0, 0); ws(0, 32'd0, 0);
    cyc(1, C_MEI, 0);
    cyc(1, C_MEI, 0);
    ack = 1'b1; cyc(0, C_MEI, 1);
    ack = 1'b0; meip = 1'b0; cyc(0, C_MEI, 1); ws(0, C_MEI, 1);
    mret = 1'b1; cyc(0, C_MEI, 0);
    mret = 1'b0; cyc(0, C_MEI, 0); cyc(0, C_MEI, 0);

    // All three sources: MEI, then MSI, then MTI
    mtie = 1'b1; msie = 1'b1;
    meip = 1'b1; msip = 1'b1; mtip = 1'b1;
    cyc(0, C_MEI, 0); ws(0, C_MEI, 0);
    cyc(1, C_MEI, 0);
    ack = 1'b1; cyc(0, C_MEI, 1);
    ack = 1'b0; meip = 1'b0; cyc(0, C_MEI, 1); ws(0, C_MEI, 1);
    mret = 1'b1; cyc(0, C_MEI, 0);
    mret = 1'b0; cyc(1, C_MSI, 0);
    ack = 1'b1; cyc(0, C_MSI, 1);
    ack = 1'b0; msip = 1'b0; cyc(0, C_MSI, 1); ws(0, C_MSI, 1);
    mret = 1'b1; cyc(0, C_MSI, 0);
    mret = 1'b0; cyc(1, C_MTI, 0);

    // Higher-priority arrival during REQ leaves mcause alone
    meip = 1'b1; cyc(1, C_MTI, 0); ws(1, C_MTI, 0); cyc(1, C_MTI, 0);

    // Withdrawal when the latched source drops
    meip = 1'b0; mtip = 1'b0; cyc(1, C_MTI, 0); ws(1, C_MTI, 0);
    cyc(0, C_MTI, 0);
    cyc(0, C_MTI, 0);

    // Withdrawal when the global enable drops
    mtip = 1'b1; cyc(0, C_MTI, 0); ws(0, C_MTI, 0); cyc(1, C_MTI, 0);
    mie = 1'b0; cyc(0, C_MTI, 0);
    mtip = 1'b0; cyc(0, C_MTI, 0); ws(0, C_MTI, 0);
    mie = 1'b1; cyc(0, C_MTI, 0);

    // Acknowledge wins over a simultaneous withdrawal condition
    msip = 1'b1; cyc(0, C_MTI, 0); ws(0, C_MTI, 0); cyc(1, C_MSI, 0);
    ack = 1'b1; mie = 1'b0; msip = 1'b0; cyc(0, C_MSI, 1);
    ack = 1'b0; cyc(0, C_MSI, 1); ws(0, C_MSI, 1);
    mie = 1'b1; mret = 1'b1; cyc(0, C_MSI, 0);
    mret = 1'b0; cyc(0, C_MSI, 0);

    // Stray mret/ack in IDLE are ignored
    mret = 1'b1; cyc(0, C_MSI, 0);
    mret = 1'b0; ack = 1'b1; cyc(0, C_MSI, 0);
    ack = 1'b0;

    // Reset mid-ACTIVE clears everything without a clock edge
    mtip = 1'b1; cyc(0, C_MSI, 0); ws(0, C_MSI, 0); cyc(1, C_MTI, 0);
    ack = 1'b1; cyc(0, C_MTI, 1);
    ack = 1'b0; mie = 1'b0; meip = 1'b1; msip = 1'b1; cyc(0, C_MTI, 1);
    rst_n = 1'b0;
    #1;
    check_val("async_trap_req", 32'(trap_req), 32'd0);
    check_val("async_irq_active", 32'(irq_active), 32'd0);
    check_val("async_mcause", mcause, 32'd0);
    check_val("async_mip_reg", mip_reg, 32'd0);
    csr_addr = 12'h344; #1;
    check_val("mip_hit_344", 32'(mip_hit), 32'd1);
    csr_addr = 12'h300; #1;
    check_val("mip_hit_300", 32'(mip_hit), 32'd0);
    csr_addr = 12'h344;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 32'd0, 0); ws(0, 32'd0, 0);
    check_val("mip_reg_all", mip_reg, 32'h00000888);
    check_val("mip_hit_hold", 32'(mip_hit), 32'd1);
    mie = 1'b1; cyc(1, C_MEI, 0);
    ack = 1'b1; cyc(0, C_MEI, 1);
    ack = 1'b0;

    @(posedge clk); #2;
    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
